// File: rtl/cnn_mem_loader_pkg.sv
// Shared definitions for the CNN memory loader.
// - Core memory port widths, kept equal to the core's width macros.
// - Default stream counts for one inference.
// - FSM state encoding and a small helper for sizing the beat counter.
package cnn_mem_loader_pkg;

    // Core memory port widths
    localparam int unsigned DATA_WIDTH     = 16;
    localparam int unsigned CTX_BITS       = 24;
    localparam int unsigned CRAM_ADDR_BITS = 6;
    localparam int unsigned WRAM_ADDR_BITS = 14;
    localparam int unsigned BRAM_ADDR_BITS = 8;
    localparam int unsigned PE_NUM_BITS    = 5;
    localparam int unsigned LDM_NUM_BITS   = 1;
    localparam int unsigned LDM_ADDR_BITS  = 8;
    localparam int unsigned LDM_AW         = PE_NUM_BITS + LDM_NUM_BITS + LDM_ADDR_BITS;
    localparam int unsigned LABEL          = 16;

    // Default counts for one inference
    localparam int unsigned DEF_CTX_COUNT    = 38;
    localparam int unsigned DEF_WEIGHT_COUNT = 10920;
    localparam int unsigned DEF_BIAS_COUNT   = 145;
    localparam int unsigned DEF_SIG_COUNT    = 320;
    localparam int unsigned DEF_PE_NUM       = 20;

    typedef enum logic [2:0] {
        StIdle,
        StLdCtx,
        StLdW,
        StLdB,
        StLdSig,
        StStart,
        StRun,
        StDone
    } loader_state_e;

    function automatic int unsigned max4(input int unsigned a, input int unsigned b,
                                         input int unsigned c, input int unsigned d);
        int unsigned m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        return m;
    endfunction

endpackage

// File: rtl/cnn_ldm_addr_gen.sv
// LDM scatter address generator.
// Signal beat k goes to pe = k mod PE_NUM, word = k div PE_NUM, built from a
// pe counter that wraps at PE_NUM-1 and bumps the word counter on wrap.
// Ports:
//   CLK, RST   clock, asynchronous active-high reset
//   clear      zero both counters (new load)
//   step       advance to the next beat
//   ldm_addr   {pe, LDM_SEL, word} for the current beat
module cnn_ldm_addr_gen
    import cnn_mem_loader_pkg::*;
#(
    parameter int unsigned PE_NUM  = DEF_PE_NUM,
    parameter int unsigned LDM_SEL = 0
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              clear,
    input  logic              step,
    output logic [LDM_AW-1:0] ldm_addr
);

    localparam logic [PE_NUM_BITS-1:0] PE_LAST = PE_NUM_BITS'(PE_NUM - 1);

    logic [PE_NUM_BITS-1:0]   pe_q, pe_d;
    logic [LDM_ADDR_BITS-1:0] word_q, word_d;

    always_comb begin
        pe_d   = pe_q;
        word_d = word_q;
        if (clear) begin
            pe_d   = '0;
            word_d = '0;
        end else if (step) begin
            if (pe_q == PE_LAST) begin
                pe_d   = '0;
                word_d = word_q + 1'b1;
            end else begin
                pe_d = pe_q + 1'b1;
            end
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            pe_q   <= '0;
            word_q <= '0;
        end else begin
            pe_q   <= pe_d;
            word_q <= word_d;
        end
    end

    assign ldm_addr = {pe_q, LDM_NUM_BITS'(LDM_SEL), word_q};

endmodule

// File: rtl/cnn_mem_loader.sv
// CNN memory loader: takes one ready/valid word stream and writes it, in
// order, into CRAM, WRAM, BRAM and LDM (LDM scattered round-robin over PEs),
// then pulses the core start, waits for completion and holds the label.
// Ports:
//   CLK, RST                 clock, asynchronous active-high reset
//   go_in, load_all_in       run request (full load or signals only)
//   s_data_in/valid/ready    input word stream
//   CRAM/WRAM/BRAM/LDM_*     core memory write ports (one-cycle ena=wea pulses)
//   start_out, complete_in   core handshake
//   label_in/out, label_valid_out, label_ready_in  label capture and hand-off
//   busy_out                 high whenever not idle
module cnn_mem_loader
    import cnn_mem_loader_pkg::*;
#(
    parameter int unsigned IN_W         = 32,
    parameter int unsigned CTX_COUNT    = DEF_CTX_COUNT,
    parameter int unsigned WEIGHT_COUNT = DEF_WEIGHT_COUNT,
    parameter int unsigned BIAS_COUNT   = DEF_BIAS_COUNT,
    parameter int unsigned PE_NUM       = DEF_PE_NUM,
    parameter int unsigned SIG_COUNT    = DEF_SIG_COUNT,
    parameter int unsigned LDM_SEL      = 0
) (
    input  logic                      CLK,
    input  logic                      RST,
    input  logic                      go_in,
    input  logic                      load_all_in,
    input  logic [IN_W-1:0]           s_data_in,
    input  logic                      s_valid_in,
    output logic                      s_ready_out,
    output logic [CRAM_ADDR_BITS-1:0] CRAM_addra_out,
    output logic [CTX_BITS-1:0]       CRAM_dina_out,
    output logic                      CRAM_ena_out,
    output logic                      CRAM_wea_out,
    output logic [WRAM_ADDR_BITS-1:0] WRAM_addra_out,
    output logic [DATA_WIDTH-1:0]     WRAM_dina_out,
    output logic                      WRAM_ena_out,
    output logic                      WRAM_wea_out,
    output logic [BRAM_ADDR_BITS-1:0] BRAM_addra_out,
    output logic [DATA_WIDTH-1:0]     BRAM_dina_out,
    output logic                      BRAM_ena_out,
    output logic                      BRAM_wea_out,
    output logic [LDM_AW-1:0]         LDM_addra_out,
    output logic [DATA_WIDTH-1:0]     LDM_dina_out,
    output logic                      LDM_ena_out,
    output logic                      LDM_wea_out,
    output logic                      start_out,
    input  logic                      complete_in,
    input  logic [LABEL-1:0]          label_in,
    output logic [LABEL-1:0]          label_out,
    output logic                      label_valid_out,
    input  logic                      label_ready_in,
    output logic                      busy_out
);

    localparam int unsigned MAX_COUNT = max4(CTX_COUNT, WEIGHT_COUNT, BIAS_COUNT, SIG_COUNT);
    localparam int unsigned CNT_W     = $clog2(MAX_COUNT + 1);

    localparam logic [CNT_W-1:0] CTX_LAST = CNT_W'(CTX_COUNT - 1);
    localparam logic [CNT_W-1:0] W_LAST   = CNT_W'(WEIGHT_COUNT - 1);
    localparam logic [CNT_W-1:0] B_LAST   = CNT_W'(BIAS_COUNT - 1);
    localparam logic [CNT_W-1:0] SIG_LAST = CNT_W'(SIG_COUNT - 1);

    loader_state_e state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic in_load;
    logic accept;
    logic beat_last;
    logic ldm_clear;
    logic [LDM_AW-1:0] ldm_addr_cur;

    logic [CRAM_ADDR_BITS-1:0] cram_addr_q;
    logic [CTX_BITS-1:0]       cram_din_q;
    logic                      cram_en_q;
    logic [WRAM_ADDR_BITS-1:0] wram_addr_q;
    logic [DATA_WIDTH-1:0]     wram_din_q;
    logic                      wram_en_q;
    logic [BRAM_ADDR_BITS-1:0] bram_addr_q;
    logic [DATA_WIDTH-1:0]     bram_din_q;
    logic                      bram_en_q;
    logic [LDM_AW-1:0]         ldm_addr_q;
    logic [DATA_WIDTH-1:0]     ldm_din_q;
    logic                      ldm_en_q;
    logic                      start_q;
    logic [LABEL-1:0]          label_q;

    // Upper stream bits are deliberately dropped by the narrower ports.
    logic unused_data;
    assign unused_data = ^s_data_in;

    assign in_load = (state_q == StLdCtx) || (state_q == StLdW) ||
                     (state_q == StLdB)   || (state_q == StLdSig);
    assign accept  = s_valid_in && in_load;

    always_comb begin
        state_d   = state_q;
        beat_last = 1'b0;
        ldm_clear = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (go_in) begin
                    ldm_clear = 1'b1;
                    state_d   = load_all_in ? StLdCtx : StLdSig;
                end
            end
            StLdCtx: begin
                beat_last = (cnt_q == CTX_LAST);
                if (accept && beat_last) state_d = StLdW;
            end
            StLdW: begin
                beat_last = (cnt_q == W_LAST);
                if (accept && beat_last) state_d = StLdB;
            end
            StLdB: begin
                beat_last = (cnt_q == B_LAST);
                if (accept && beat_last) state_d = StLdSig;
            end
            StLdSig: begin
                beat_last = (cnt_q == SIG_LAST);
                if (accept && beat_last) state_d = StStart;
            end
            StStart: state_d = StRun;
            StRun: begin
                if (complete_in) state_d = StDone;
            end
            StDone: begin
                if (label_ready_in) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    // Beat index within the current load state; restarts at each state change.
    always_comb begin
        cnt_d = cnt_q;
        if (accept) cnt_d = beat_last ? '0 : cnt_q + 1'b1;
    end

    cnn_ldm_addr_gen #(
        .PE_NUM  (PE_NUM),
        .LDM_SEL (LDM_SEL)
    ) u_ldm_addr_gen (
        .CLK      (CLK),
        .RST      (RST),
        .clear    (ldm_clear),
        .step     (accept && (state_q == StLdSig)),
        .ldm_addr (ldm_addr_cur)
    );

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            cram_addr_q <= '0;
            cram_din_q  <= '0;
            cram_en_q   <= 1'b0;
            wram_addr_q <= '0;
            wram_din_q  <= '0;
            wram_en_q   <= 1'b0;
            bram_addr_q <= '0;
            bram_din_q  <= '0;
            bram_en_q   <= 1'b0;
            ldm_addr_q  <= '0;
            ldm_din_q   <= '0;
            ldm_en_q    <= 1'b0;
            start_q     <= 1'b0;
            label_q     <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            cram_en_q <= accept && (state_q == StLdCtx);
            wram_en_q <= accept && (state_q == StLdW);
            bram_en_q <= accept && (state_q == StLdB);
            ldm_en_q  <= accept && (state_q == StLdSig);
            // Registered so the final LDM write lands a cycle ahead of start.
            start_q   <= (state_q == StStart);
            if (accept && (state_q == StLdCtx)) begin
                cram_addr_q <= CRAM_ADDR_BITS'(cnt_q);
                cram_din_q  <= s_data_in[CTX_BITS-1:0];
            end
            if (accept && (state_q == StLdW)) begin
                wram_addr_q <= WRAM_ADDR_BITS'(cnt_q);
                wram_din_q  <= s_data_in[DATA_WIDTH-1:0];
            end
            if (accept && (state_q == StLdB)) begin
                bram_addr_q <= BRAM_ADDR_BITS'(cnt_q);
                bram_din_q  <= s_data_in[DATA_WIDTH-1:0];
            end
            if (accept && (state_q == StLdSig)) begin
                ldm_addr_q <= ldm_addr_cur;
                ldm_din_q  <= s_data_in[DATA_WIDTH-1:0];
            end
            if ((state_q == StRun) && complete_in) label_q <= label_in;
        end
    end

    assign s_ready_out     = in_load;
    assign CRAM_addra_out  = cram_addr_q;
    assign CRAM_dina_out   = cram_din_q;
    assign CRAM_ena_out    = cram_en_q;
    assign CRAM_wea_out    = cram_en_q;
    assign WRAM_addra_out  = wram_addr_q;
    assign WRAM_dina_out   = wram_din_q;
    assign WRAM_ena_out    = wram_en_q;
    assign WRAM_wea_out    = wram_en_q;
    assign BRAM_addra_out  = bram_addr_q;
    assign BRAM_dina_out   = bram_din_q;
    assign BRAM_ena_out    = bram_en_q;
    assign BRAM_wea_out    = bram_en_q;
    assign LDM_addra_out   = ldm_addr_q;
    assign LDM_dina_out    = ldm_din_q;
    assign LDM_ena_out     = ldm_en_q;
    assign LDM_wea_out     = ldm_en_q;
    assign start_out       = start_q;
    assign label_out       = label_q;
    assign label_valid_out = (state_q == StDone);
    assign busy_out        = (state_q != StIdle);

endmodule

// File: tb/tb_cnn_mem_loader.sv
// Self-checking bench for cnn_mem_loader: full load, gapped load, signal-only
// rerun, label hand-off, mid-load reset and ignored inputs.
module tb_cnn_mem_loader;

    localparam int FULL_BEATS = 38 + 10920 + 145 + 320;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        go_in = 1'b0;
    logic        load_all_in = 1'b0;
    logic [31:0] s_data_in = '0;
    logic        s_valid_in = 1'b0;
    logic        s_ready_out;
    logic [5:0]  CRAM_addra_out;
    logic [23:0] CRAM_dina_out;
    logic        CRAM_ena_out, CRAM_wea_out;
    logic [13:0] WRAM_addra_out;
    logic [15:0] WRAM_dina_out;
    logic        WRAM_ena_out, WRAM_wea_out;
    logic [7:0]  BRAM_addra_out;
    logic [15:0] BRAM_dina_out;
    logic        BRAM_ena_out, BRAM_wea_out;
    logic [13:0] LDM_addra_out;
    logic [15:0] LDM_dina_out;
    logic        LDM_ena_out, LDM_wea_out;
    logic        start_out;
    logic        complete_in = 1'b0;
    logic [15:0] label_in = '0;
    logic [15:0] label_out;
    logic        label_valid_out;
    logic        label_ready_in = 1'b0;
    logic        busy_out;

    int n_checks = 0;
    int n_fail   = 0;

    // Monitor state
    int          cyc = 0;
    int          n_cram, n_wram, n_bram, n_ldm, n_start;
    int          first_cram, last_cram, last_wram, last_bram;
    int          last_ldm_cyc, start_cyc;
    int          mon_bad;
    string       bad_name;
    logic [31:0] bad_act, bad_exp;
    logic [13:0] ldm_log [0:319];
    logic        prev_fire = 1'b0;

    cnn_mem_loader dut (
        .CLK             (CLK),
        .RST             (RST),
        .go_in           (go_in),
        .load_all_in     (load_all_in),
        .s_data_in       (s_data_in),
        .s_valid_in      (s_valid_in),
        .s_ready_out     (s_ready_out),
        .CRAM_addra_out  (CRAM_addra_out),
        .CRAM_dina_out   (CRAM_dina_out),
        .CRAM_ena_out    (CRAM_ena_out),
        .CRAM_wea_out    (CRAM_wea_out),
        .WRAM_addra_out  (WRAM_addra_out),
        .WRAM_dina_out   (WRAM_dina_out),
        .WRAM_ena_out    (WRAM_ena_out),
        .WRAM_wea_out    (WRAM_wea_out),
        .BRAM_addra_out  (BRAM_addra_out),
        .BRAM_dina_out   (BRAM_dina_out),
        .BRAM_ena_out    (BRAM_ena_out),
        .BRAM_wea_out    (BRAM_wea_out),
        .LDM_addra_out   (LDM_addra_out),
        .LDM_dina_out    (LDM_dina_out),
        .LDM_ena_out     (LDM_ena_out),
        .LDM_wea_out     (LDM_wea_out),
        .start_out       (start_out),
        .complete_in     (complete_in),
        .label_in        (label_in),
        .label_out       (label_out),
        .label_valid_out (label_valid_out),
        .label_ready_in  (label_ready_in),
        .busy_out        (busy_out)
    );

    always #5 CLK = ~CLK;

    task automatic mon_note(input string name, input logic [31:0] act, input logic [31:0] exp);
        if (mon_bad == 0) begin
            bad_name = name;
            bad_act  = act;
            bad_exp  = exp;
        end
        mon_bad++;
    endtask

    task automatic clear_mon();
        n_cram = 0; n_wram = 0; n_bram = 0; n_ldm = 0; n_start = 0;
        first_cram = -1; last_cram = -1; last_wram = -1; last_bram = -1;
        last_ldm_cyc = -1; start_cyc = -1; mon_bad = 0; bad_name = "";
        for (int i = 0; i < 320; i++) ldm_log[i] = '0;
    endtask

    // Checks every write against the stream order: beat g carries {C0DE, g}.
    always @(negedge CLK) begin
        int          g;
        int          k;
        logic [31:0] w;
        logic [13:0] exp_ldm;
        logic        any_en;
        cyc++;
        if (RST) begin
            prev_fire = 1'b0;
        end else begin
            any_en = CRAM_ena_out | WRAM_ena_out | BRAM_ena_out | LDM_ena_out;
            if (any_en !== prev_fire) mon_note("write_vs_accept", 32'(any_en), 32'(prev_fire));
            if ({CRAM_ena_out, WRAM_ena_out, BRAM_ena_out, LDM_ena_out} !==
                {CRAM_wea_out, WRAM_wea_out, BRAM_wea_out, LDM_wea_out})
                mon_note("ena_eq_wea", 32'({CRAM_wea_out, WRAM_wea_out, BRAM_wea_out, LDM_wea_out}),
                         32'({CRAM_ena_out, WRAM_ena_out, BRAM_ena_out, LDM_ena_out}));
            g = n_cram + n_wram + n_bram + n_ldm;
            w = {16'hC0DE, g[15:0]};
            if (CRAM_ena_out) begin
                if (CRAM_addra_out !== 6'(n_cram)) mon_note("cram_addr", 32'(CRAM_addra_out), n_cram);
                if (CRAM_dina_out !== w[23:0]) mon_note("cram_din", 32'(CRAM_dina_out), 32'(w[23:0]));
                if (first_cram < 0) first_cram = int'(CRAM_addra_out);
                last_cram = int'(CRAM_addra_out);
                n_cram++;
            end
            if (WRAM_ena_out) begin
                if (WRAM_addra_out !== 14'(n_wram)) mon_note("wram_addr", 32'(WRAM_addra_out), n_wram);
                if (WRAM_dina_out !== w[15:0]) mon_note("wram_din", 32'(WRAM_dina_out), 32'(w[15:0]));
                last_wram = int'(WRAM_addra_out);
                n_wram++;
            end
            if (BRAM_ena_out) begin
                if (BRAM_addra_out !== 8'(n_bram)) mon_note("bram_addr", 32'(BRAM_addra_out), n_bram);
                if (BRAM_dina_out !== w[15:0]) mon_note("bram_din", 32'(BRAM_dina_out), 32'(w[15:0]));
                last_bram = int'(BRAM_addra_out);
                n_bram++;
            end
            if (LDM_ena_out) begin
                k = n_ldm;
                exp_ldm = {5'(k % 20), 1'b0, 8'(k / 20)};
                if (LDM_addra_out !== exp_ldm) mon_note("ldm_addr", 32'(LDM_addra_out), 32'(exp_ldm));
                if (LDM_dina_out !== w[15:0]) mon_note("ldm_din", 32'(LDM_dina_out), 32'(w[15:0]));
                if (k < 320) ldm_log[k] = LDM_addra_out;
                last_ldm_cyc = cyc;
                n_ldm++;
            end
            if (start_out) begin
                n_start++;
                start_cyc = cyc;
            end
            prev_fire = s_valid_in && s_ready_out;
        end
    end

    task automatic pulse_go(input logic all);
        go_in       = 1'b1;
        load_all_in = all;
        @(posedge CLK); #1;
        go_in       = 1'b0;
        load_all_in = 1'b0;
    endtask

    // Streams beats {C0DE, g}; idle_pct is the chance of a valid-low cycle.
    task automatic stream(input int beats, input int idle_pct);
        int   g = 0;
        int   budget = 0;
        logic fire;
        while (g < beats && budget < 60000) begin
            s_valid_in = ($urandom_range(0, 99) >= idle_pct);
            s_data_in  = {16'hC0DE, g[15:0]};
            @(negedge CLK);
            fire = s_valid_in && s_ready_out;
            @(posedge CLK); #1;
            if (fire) g++;
            budget++;
        end
        s_valid_in = 1'b0;
        n_checks++;
        if (g !== beats) begin
            n_fail++;
            $display("FAIL stream_accept: accepted %0d beats, required %0d", g, beats);
        end
    endtask

    task automatic wait_start();
        int t = 0;
        while (n_start == 0 && t < 50) begin
            @(posedge CLK); #1;
            t++;
        end
        repeat (5) @(posedge CLK);
        #1;
        n_checks++;
        if (n_start !== 1) begin
            n_fail++;
            $display("FAIL start_count: got %0d pulses, required 1", n_start);
        end
        n_checks++;
        if (start_cyc !== last_ldm_cyc + 1) begin
            n_fail++;
            $display("FAIL start_timing: start at cycle %0d, required %0d", start_cyc, last_ldm_cyc + 1);
        end
        n_checks++;
        if (busy_out !== 1'b1 || s_ready_out !== 1'b0) begin
            n_fail++;
            $display("FAIL run_state: busy=%b ready=%b, required busy=1 ready=0", busy_out, s_ready_out);
        end
    endtask

    task automatic check_monitor(input string scen);
        n_checks++;
        if (mon_bad !== 0) begin
            n_fail++;
            $display("FAIL %s_%s: %0d bad writes, first got %0h required %0h",
                     scen, bad_name, mon_bad, bad_act, bad_exp);
        end
    endtask

    task automatic check_full_counts(input string scen);
        n_checks++;
        if ({n_cram, n_wram, n_bram, n_ldm} !== {32'd38, 32'd10920, 32'd145, 32'd320}) begin
            n_fail++;
            $display("FAIL %s_counts: cram/wram/bram/ldm %0d/%0d/%0d/%0d, required 38/10920/145/320",
                     scen, n_cram, n_wram, n_bram, n_ldm);
        end
        n_checks++;
        if (first_cram !== 0 || last_cram !== 37) begin
            n_fail++;
            $display("FAIL %s_cram_range: %0d..%0d, required 0..37", scen, first_cram, last_cram);
        end
        n_checks++;
        if (last_wram !== 10919 || last_bram !== 144) begin
            n_fail++;
            $display("FAIL %s_last_wb: wram %0d bram %0d, required 10919 and 144", scen, last_wram, last_bram);
        end
        n_checks++;
        if (ldm_log[21] !== 14'd513) begin
            n_fail++;
            $display("FAIL %s_ldm_beat21: got %0h, required %0h", scen, ldm_log[21], 14'd513);
        end
        n_checks++;
        if (ldm_log[319] !== 14'd9743) begin
            n_fail++;
            $display("FAIL %s_ldm_beat319: got %0h, required %0h", scen, ldm_log[319], 14'd9743);
        end
        check_monitor(scen);
    endtask

    task automatic finish_run();
        complete_in = 1'b1;
        label_in    = 16'h0005;
        @(posedge CLK); #1;
        complete_in = 1'b0;
        label_ready_in = 1'b1;
        @(posedge CLK); #1;
        label_ready_in = 1'b0;
        n_checks++;
        if (busy_out !== 1'b0 || label_out !== 16'h0005) begin
            n_fail++;
            $display("FAIL finish_run: busy=%b label=%0h, required busy=0 label=5", busy_out, label_out);
        end
    endtask

    task automatic test_reset();
        #2;
        n_checks++;
        if ({CRAM_ena_out, WRAM_ena_out, BRAM_ena_out, LDM_ena_out, start_out, s_ready_out,
             busy_out, label_valid_out} !== 8'b0) begin
            n_fail++;
            $display("FAIL reset_ctrl: got %b, required 00000000",
                     {CRAM_ena_out, WRAM_ena_out, BRAM_ena_out, LDM_ena_out, start_out,
                      s_ready_out, busy_out, label_valid_out});
        end
        n_checks++;
        if (label_out !== 16'h0 || CRAM_addra_out !== 6'h0 || LDM_addra_out !== 14'h0) begin
            n_fail++;
            $display("FAIL reset_data: label=%0h cram_addr=%0h ldm_addr=%0h, required all 0",
                     label_out, CRAM_addra_out, LDM_addra_out);
        end
        repeat (3) @(posedge CLK);
        #1;
        RST = 1'b0;
        @(posedge CLK); #1;
    endtask

    task automatic test_full_load();
        clear_mon();
        pulse_go(1'b1);
        stream(FULL_BEATS, 0);
        wait_start();
        check_full_counts("full");
    endtask

    // Entered in RUN after test_full_load.
    task automatic test_label_and_busy_ignores();
        int n_before;
        n_before = n_cram + n_wram + n_bram + n_ldm;
        repeat (200) @(posedge CLK);
        #1;
        go_in = 1'b1; load_all_in = 1'b1; s_valid_in = 1'b1;
        repeat (3) @(posedge CLK);
        #1;
        go_in = 1'b0; load_all_in = 1'b0; s_valid_in = 1'b0;
        repeat (297) @(posedge CLK);
        #1;
        n_checks++;
        if (n_cram + n_wram + n_bram + n_ldm !== n_before || n_start !== 1 || busy_out !== 1'b1 ||
            label_valid_out !== 1'b0) begin
            n_fail++;
            $display("FAIL run_ignores_go: writes %0d starts %0d busy %b valid %b, required %0d 1 1 0",
                     n_cram + n_wram + n_bram + n_ldm, n_start, busy_out, label_valid_out, n_before);
        end
        complete_in = 1'b1;
        label_in    = 16'd3;
        @(posedge CLK); #1;
        complete_in = 1'b0;
        label_in    = 16'd9;
        n_checks++;
        if (label_out !== 16'd3 || label_valid_out !== 1'b1) begin
            n_fail++;
            $display("FAIL label_capture: label=%0d valid=%b, required 3 and 1", label_out, label_valid_out);
        end
        for (int i = 0; i < 10; i++) begin
            label_in = 16'(i + 10);
            @(posedge CLK); #1;
            n_checks++;
            if (label_out !== 16'd3 || label_valid_out !== 1'b1 || busy_out !== 1'b1) begin
                n_fail++;
                $display("FAIL label_hold_%0d: label=%0d valid=%b busy=%b, required 3 1 1",
                         i, label_out, label_valid_out, busy_out);
            end
        end
        label_ready_in = 1'b1;
        @(posedge CLK); #1;
        label_ready_in = 1'b0;
        n_checks++;
        if (label_valid_out !== 1'b0 || busy_out !== 1'b0) begin
            n_fail++;
            $display("FAIL label_release: valid=%b busy=%b, required 0 0", label_valid_out, busy_out);
        end
    endtask

    task automatic test_gapped_load();
        clear_mon();
        pulse_go(1'b1);
        stream(FULL_BEATS, 30);
        wait_start();
        check_full_counts("gapped");
        finish_run();
    endtask

    task automatic test_rerun();
        clear_mon();
        pulse_go(1'b0);
        stream(320, 10);
        wait_start();
        n_checks++;
        if ({n_cram, n_wram, n_bram, n_ldm} !== {32'd0, 32'd0, 32'd0, 32'd320}) begin
            n_fail++;
            $display("FAIL rerun_counts: cram/wram/bram/ldm %0d/%0d/%0d/%0d, required 0/0/0/320",
                     n_cram, n_wram, n_bram, n_ldm);
        end
        n_checks++;
        if (ldm_log[21] !== 14'd513 || ldm_log[319] !== 14'd9743) begin
            n_fail++;
            $display("FAIL rerun_ldm_addr: beat21 %0h beat319 %0h, required 201 260f",
                     ldm_log[21], ldm_log[319]);
        end
        check_monitor("rerun");
        finish_run();
    endtask

    task automatic test_reset_mid_load();
        clear_mon();
        pulse_go(1'b1);
        stream(38 + 5001, 0);
        n_checks++;
        if (WRAM_ena_out !== 1'b1 || WRAM_addra_out !== 14'd5000) begin
            n_fail++;
            $display("FAIL midload_pending: wram ena=%b addr=%0d, required 1 and 5000",
                     WRAM_ena_out, WRAM_addra_out);
        end
        #1 RST = 1'b1;
        #1;
        n_checks++;
        if ({CRAM_ena_out, WRAM_ena_out, WRAM_wea_out, BRAM_ena_out, LDM_ena_out, start_out,
             s_ready_out, busy_out} !== 8'b0) begin
            n_fail++;
            $display("FAIL async_reset: got %b, required 00000000",
                     {CRAM_ena_out, WRAM_ena_out, WRAM_wea_out, BRAM_ena_out, LDM_ena_out,
                      start_out, s_ready_out, busy_out});
        end
        @(posedge CLK); #1;
        RST = 1'b0;
        @(posedge CLK); #1;
        clear_mon();
        pulse_go(1'b1);
        stream(3, 0);
        @(posedge CLK); #1;
        n_checks++;
        if (n_cram !== 3 || first_cram !== 0 || last_cram !== 2 || n_wram !== 0) begin
            n_fail++;
            $display("FAIL restart_cram: n=%0d first=%0d last=%0d wram=%0d, required 3 0 2 0",
                     n_cram, first_cram, last_cram, n_wram);
        end
        check_monitor("restart");
        RST = 1'b1;
        @(posedge CLK); #1;
        RST = 1'b0;
        @(posedge CLK); #1;
    endtask

    task automatic test_idle_ignores();
        clear_mon();
        s_valid_in  = 1'b1;
        complete_in = 1'b1;
        repeat (20) @(posedge CLK);
        #1;
        n_checks++;
        if (s_ready_out !== 1'b0 || busy_out !== 1'b0 || label_valid_out !== 1'b0) begin
            n_fail++;
            $display("FAIL idle_state: ready=%b busy=%b valid=%b, required 0 0 0",
                     s_ready_out, busy_out, label_valid_out);
        end
        s_valid_in  = 1'b0;
        complete_in = 1'b0;
        @(posedge CLK); #1;
        n_checks++;
        if (n_cram + n_wram + n_bram + n_ldm + n_start !== 0) begin
            n_fail++;
            $display("FAIL idle_writes: got %0d writes/starts, required 0",
                     n_cram + n_wram + n_bram + n_ldm + n_start);
        end
        check_monitor("idle");
    endtask

    initial begin
        clear_mon();
        test_reset();
        test_idle_ignores();
        test_full_load();
        test_label_and_busy_ignores();
        test_gapped_load();
        test_rerun();
        test_reset_mid_load();
        test_idle_ignores();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #3_000_000;
        $display("FAIL timeout: simulation did not finish, required finish before 3000000");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/cnn_mem_loader.md
Name: cnn_mem_loader

Overview:
- Synthesizable front-end sequencer directly upstream of the CNN core. It replaces the bench-driven memory fill.
- Accepts one ready/valid word stream and writes it in fixed order into the core's CRAM, WRAM, BRAM and LDM write ports. LDM words are scattered round-robin across PEs.
- Pulses the core's start, waits for its completion, then captures and holds the classification label until acknowledged.

Parameters:
- IN_W, 32: stream data width; each memory takes the low bits it needs.
- CTX_COUNT, 38: context words written to CRAM addr 0..37.
- WEIGHT_COUNT, 10920: weight words written to WRAM addr 0..10919.
- BIAS_COUNT, 145: bias words written to BRAM addr 0..144.
- PE_NUM, 20: PEs receiving signal samples.
- SIG_COUNT, 320: signal samples per inference; must be a multiple of PE_NUM.
- LDM_SEL, 0: LDM bank index placed in the LDM address.
- All counts must be ≥1.

Ports:
- CLK  in  1  system clock.
- RST  in  1  reset; asynchronous, active-high.
- go_in  in  1  one-cycle request; sampled only in IDLE.
- load_all_in  in  1  sampled with go_in. 1 = full load (ctx/weight/bias/signal); 0 = signals only.
- s_data_in  in  IN_W  stream word.
- s_valid_in  in  1  stream valid.
- s_ready_out  out  1  stream ready.
- CRAM_addra_out / CRAM_dina_out / CRAM_ena_out / CRAM_wea_out  out  `CRAM_ADDR_BITS / `CTX_BITS / 1 / 1  CRAM write port.
- WRAM_addra_out / WRAM_dina_out / WRAM_ena_out / WRAM_wea_out  out  `WRAM_ADDR_BITS / `DATA_WIDTH / 1 / 1  WRAM write port.
- BRAM_addra_out / BRAM_dina_out / BRAM_ena_out / BRAM_wea_out  out  `BRAM_ADDR_BITS / `DATA_WIDTH / 1 / 1  BRAM write port.
- LDM_addra_out / LDM_dina_out / LDM_ena_out / LDM_wea_out  out  `PE_NUM_BITS+`LDM_NUM_BITS+`LDM_ADDR_BITS / `DATA_WIDTH / 1 / 1  LDM write port.
- start_out  out  1  one-cycle start to the core.
- complete_in  in  1  core completion.
- label_in  in  `LABEL  core label (core's LDM douta).
- label_out  out  `LABEL  captured label.
- label_valid_out  out  1  label held valid.
- label_ready_in  in  1  label acknowledge.
- busy_out  out  1  high in every state except IDLE.

Behaviour:
- Reset: all outputs 0, FSM in IDLE, all counters 0. Assertion mid-operation aborts immediately; no partial-write completion.
- FSM states: IDLE, LD_CTX, LD_W, LD_B, LD_SIG, START, RUN, DONE.
- IDLE: on go_in, go to LD_CTX if load_all_in=1, else LD_SIG. s_valid_in is ignored in IDLE.
- Load states: s_ready_out=1 combinationally while in the state.
- Beat accepted (s_valid_in & s_ready_out) in cycle N:
  - Cycle N+1 drives addr/din with ena=wea=1 on the target port, for exactly one cycle.
  - Otherwise ena=wea=0; addr/din hold their last value.
  - No bubbles: back-to-back beats produce back-to-back writes.
- Addresses:
  - CRAM/WRAM/BRAM: address = beat index within the state.
  - LDM beat k: pe = k mod PE_NUM, addr = k div PE_NUM. LDM address = {pe, LDM_SEL, addr}. Implemented with a pe counter that wraps at PE_NUM-1 and increments addr on wrap; no divider.
- Data: low bits of s_data_in, truncated to the port width.
- Transitions: the last beat of each load state moves to the next state in the same edge, with s_ready_out dropping the next cycle.
  - Order: LD_CTX → LD_W → LD_B → LD_SIG → START.
  - The final LDM write (cycle after last beat) coincides with the first cycle of START.
  - start_out rises only in the cycle after START is entered, so the last write lands before start.
- START: start_out=1 for one cycle, then RUN.
- RUN: wait for complete_in. On the first cycle it is high, register label_in into label_out and go to DONE. complete_in outside RUN is ignored.
- DONE: label_valid_out=1 and label_out stable until label_ready_in=1. Then label_valid_out=0 and return to IDLE the next cycle.
- Re-run: weights persist in the core, so go_in with load_all_in=0 reruns inference on new signals only.
- go_in while busy: ignored.

Decomposition:
- Shared package/header: FSM state encoding constants and the default counts (CTX_COUNT, WEIGHT_COUNT, BIAS_COUNT, SIG_COUNT). Reuse the existing width macros from common.vh.
- One natural sub-module: cnn_ldm_addr_gen (pe/addr counter pair with wrap, LDM address concatenation).

Test Plan:
- Full load, continuous valid, CTX=38/W=10920/B=145/SIG=320 → 38, 10920, 145, 320 write pulses on the respective ports.
  - CRAM addr 0..37, last WRAM addr 10919, last BRAM addr 144.
  - LDM beat 21 → pe=1, addr=1; beat 319 → pe=19, addr=15.
  - start_out pulses once, one cycle after the final LDM write.
- Random s_valid_in gaps (30% idle) → identical write sequence and addresses; no write during gap cycles.
- After a completed full run, go_in with load_all_in=0 → zero CRAM/WRAM/BRAM writes, 320 LDM writes, start_out pulse.
- RUN with complete_in high after 500 cycles and label_in=3 → label_out=3 and label_valid_out=1.
  - Holds while label_ready_in=0 for 10 cycles even if label_in changes.
  - After ready, IDLE and busy_out=0.
- RST asserted mid LD_W (beat 5000) → all ena/wea/start 0 asynchronously, IDLE.
  - A new full go_in restarts at CRAM addr 0.
- go_in pulsed during RUN, and s_valid_in high in IDLE → no effect; no writes, state unchanged.
